// File: rtl/division_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and constants for the sequential divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } div_state_t;

   // Quotient reported on divide-by-zero; sliced down to the operand width.
   localparam logic [63:0] DIV0_FILL = '1;

endpackage
`default_nettype wire

// File: rtl/division_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : division_seq_if
//  Description : Start/done handshake and operand/result bundle for the
//                sequential divider.
//  Revision    : 1.0 - initial release
// ============================================================================
interface division_seq_if #(
   parameter int N = 4
);
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [N-1:0] result;
   logic [N-1:0] remainder;
   logic         flagC;
   logic         flagV;
   logic         flagZ;
   logic         busy;
   logic         done;

   modport master (
      output start, a, b,
      input  result, remainder, flagC, flagV, flagZ, busy, done
   );

   modport slave (
      input  start, a, b,
      output result, remainder, flagC, flagV, flagZ, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/division_seq_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One restoring-division step: shift in one dividend bit,
//                compare against the divisor, conditionally subtract.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
   parameter int N = 4
) (
   input  logic [N-1:0] rem_in,
   input  logic         in_bit,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] rem_out,
   output logic         q_bit
);
   logic [N:0]   shifted;
   logic [N-1:0] diff;

   // Compare on N+1 bits so a partial remainder with its top bit set is
   // never truncated; the difference always fits in N bits when taken.
   always_comb begin
      shifted = {rem_in, in_bit};
      q_bit   = (shifted >= {1'b0, divisor});
      diff    = shifted[N-1:0] - divisor;
      rem_out = q_bit ? diff : shifted[N-1:0];
   end
endmodule
`default_nettype wire

// File: rtl/division_seq.sv
`default_nettype none
// ============================================================================
//  Module      : division_seq
//  Description : Sequential unsigned restoring divider, one quotient bit per
//                clock, with ALU-style C/V/Z flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module division_seq
   import div_pkg::*;
#(
   parameter int N = 4
) (
   input  logic            clk,
   input  logic            rst,
   division_seq_if.slave   bus
);
   localparam int CW = $clog2(N);

   div_state_t   state;
   div_state_t   state_next;

   logic [N-1:0]  dividend;     // shifts left; quotient bits enter at LSB
   logic [N-1:0]  divisor;
   logic [N-1:0]  rem;
   logic [CW-1:0] count;

   logic [N-1:0]  result_q;
   logic [N-1:0]  remainder_q;
   logic          flag_c;
   logic          flag_v;
   logic          flag_z;

   logic [N-1:0]  rem_next;
   logic          q_bit;
   logic [N-1:0]  quot_next;

   logic          load_op;
   logic          load_div0;
   logic          last_step;

   div_step #(.N(N)) u_step (
      .rem_in  (rem),
      .in_bit  (dividend[N-1]),
      .divisor (divisor),
      .rem_out (rem_next),
      .q_bit   (q_bit)
   );

   assign quot_next = {dividend[N-2:0], q_bit};

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state decode; FIN accepts a start exactly like IDLE.
   always_comb begin
      state_next = state;
      load_op    = 1'b0;
      load_div0  = 1'b0;
      last_step  = 1'b0;
      case (state)
         IDLE, FIN: begin
            state_next = IDLE;
            if (bus.start) begin
               if (bus.b == '0) begin
                  load_div0  = 1'b1;
                  state_next = FIN;
               end else begin
                  load_op    = 1'b1;
                  state_next = CALC;
               end
            end
         end
         CALC: begin
            if (count == '0) begin
               last_step  = 1'b1;
               state_next = FIN;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath and result registers; results persist until the next load.
   always_ff @(posedge clk) begin
      if (rst) begin
         dividend    <= '0;
         divisor     <= '0;
         rem         <= '0;
         count       <= '0;
         result_q    <= '0;
         remainder_q <= '0;
         flag_c      <= 1'b0;
         flag_v      <= 1'b0;
         flag_z      <= 1'b0;
      end else begin
         if (load_op) begin
            dividend <= bus.a;
            divisor  <= bus.b;
            rem      <= '0;
            count    <= CW'(N - 1);
         end
         if (load_div0) begin
            result_q    <= DIV0_FILL[N-1:0];
            remainder_q <= bus.a;
            flag_v      <= 1'b1;
            flag_c      <= (bus.a != '0);
            flag_z      <= 1'b0;
         end
         if (state == CALC) begin
            dividend <= quot_next;
            rem      <= rem_next;
            count    <= count - 1'b1;
         end
         if (last_step) begin
            result_q    <= quot_next;
            remainder_q <= rem_next;
            flag_z      <= (quot_next == '0);
            flag_c      <= (rem_next != '0);
            flag_v      <= 1'b0;
         end
      end
   end

   assign bus.result    = result_q;
   assign bus.remainder = remainder_q;
   assign bus.flagC     = flag_c;
   assign bus.flagV     = flag_v;
   assign bus.flagZ     = flag_z;
   assign bus.busy      = (state == CALC);
   assign bus.done      = (state == FIN);
endmodule
`default_nettype wire
